// File: rtl/add_pkg.sv
// add_pkg: shared word width, controller states and word-select helper.
package add_pkg;
  localparam int WORD_W = 16;
  localparam int MAX_W = WORD_W * 8;
  typedef enum logic [1:0] {IDLE, ADD, DONE} mac_state_t;
  function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_W-1:0] v, input logic [2:0] idx);
    return v[WORD_W*idx +: WORD_W];
  endfunction
endpackage

// File: rtl/word_counter.sv
// word_counter: word index counter with clear, enable and terminal-count flag.
module word_counter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          tc
);
  assign tc = idx == IW'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) idx <= '0;
    else if (clr) idx <= '0;
    else if (en && !tc) idx <= idx + 1'b1;
endmodule

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: sequences a multi-word add through one external 16-bit adder slice.
module multiword_add_ctrl
  import add_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WORD_W*NUM_WORDS-1:0] op_a,
  input  logic [WORD_W*NUM_WORDS-1:0] op_b,
  input  logic                    cin,
  output logic [WORD_W-1:0]       add_a,
  output logic [WORD_W-1:0]       add_b,
  output logic                    add_cin,
  input  logic [WORD_W-1:0]       add_sum,
  input  logic                    add_ovf,
  output logic                    busy,
  output logic                    done,
  output logic [WORD_W*NUM_WORDS-1:0] result,
  output logic                    carry_out
);
  localparam int W = WORD_W * NUM_WORDS;
  localparam int IW = $clog2(NUM_WORDS);
  mac_state_t state, state_nx;
  logic [W-1:0] a_r, b_r;
  logic carry_reg, tc;
  logic [IW-1:0] idx;
  word_counter #(.N(NUM_WORDS)) u_cnt (
    .clk(clk), .rst(rst), .clr(state != ADD), .en(state == ADD), .idx(idx), .tc(tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? ADD : IDLE) :
               state == ADD  ? (tc ? DONE : ADD) : IDLE;
  assign busy = state == ADD;
  assign done = state == DONE;
  assign add_a = busy ? word_sel(MAX_W'(a_r), 3'(idx)) : '0;
  assign add_b = busy ? word_sel(MAX_W'(b_r), 3'(idx)) : '0;
  assign add_cin = busy & carry_reg;
  // Result words are written in place as the carry ripples upward.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      carry_reg <= 1'b0;
      result <= '0;
      carry_out <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r <= op_a;
      b_r <= op_b;
      carry_reg <= cin;
    end else if (state == ADD) begin
      result[WORD_W*idx +: WORD_W] <= add_sum;
      carry_reg <= add_ovf;
      if (tc) carry_out <= add_ovf;
    end
  a_ovf_known: assert property (@(posedge clk) disable iff (rst) (state == ADD) |-> !$isunknown(add_ovf));
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb_multiword_add_ctrl: random and directed checks against a cycle-count reference model with a result scoreboard.
module tb_multiword_add_ctrl;
  localparam int N = 4;
  localparam int W = 16 * N;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [W-1:0] op_a = '0, op_b = '0, result;
  logic [15:0] add_a, add_b, add_sum;
  logic add_cin, add_ovf, busy, done, carry_out;
  int tests = 0, fails = 0, rem = 0;
  logic [W:0] q[$];
  logic [W-1:0] lat_a, lat_b;
  logic lat_cin;

  multiword_add_ctrl #(.NUM_WORDS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_ovf(add_ovf),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  assign {add_ovf, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Reference: an accepted request occupies N+1 cycles (N busy, then one done).
  always @(posedge clk or posedge rst)
    if (rst) begin
      rem = 0;
      q.delete();
    end else if (rem > 0) rem--;
    else if (start) begin
      lat_a = op_a;
      lat_b = op_b;
      lat_cin = cin;
      q.push_back((W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(cin));
      rem = N + 1;
    end

  always @(negedge clk) begin
    logic [W:0] m, exp_r;
    int w;
    chk("busy", 80'(busy), 80'(rem >= 2));
    chk("done", 80'(done), 80'(rem == 1));
    if (rem >= 2) begin
      w = N + 1 - rem;
      m = ((W+1)'(1) << (16 * w)) - 1'b1;
      chk("slice_a", 80'(add_a), 80'(lat_a[16*w +: 16]));
      chk("slice_b", 80'(add_b), 80'(lat_b[16*w +: 16]));
      chk("slice_cin", 80'(add_cin),
          80'(((((W+1)'(lat_a) & m) + ((W+1)'(lat_b) & m) + (W+1)'(lat_cin)) >> (16 * w)) & 1));
    end else chk("idle_drive", 80'({add_a, add_b, add_cin}), 80'(0));
    if (done) begin
      if (q.size() == 0) chk("done_unexpected", 80'(1), 80'(0));
      else begin
        exp_r = q.pop_front();
        chk("result", 80'({carry_out, result}), 80'(exp_r));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    cin = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    op_a = a; op_b = b; cin = c; start = 1;
    tick();
    start = 0;
    scramble();
    repeat (N + 1) tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_result", 80'(result), 80'(0));
    chk("reset_carry", 80'(carry_out), 80'(0));
    rst = 0;
    tick();
    run_op(64'h1, 64'h2, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
    run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 0);
    // start re-pulsed while busy must be ignored
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321; cin = 1; start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    scramble();
    start = 1;
    tick();
    start = 0;
    repeat (N - 2) tick();
    // reset mid-ADD aborts, then a fresh operation
    op_a = 64'hFFFF_0000_FFFF_0000; op_b = 64'h0001_FFFF_0001_FFFF; cin = 1; start = 1;
    tick();
    start = 0;
    tick();
    rst = 1;
    #1;
    chk("abort_result", 80'(result), 80'(0));
    chk("abort_carry", 80'(carry_out), 80'(0));
    chk("abort_busy", 80'(busy), 80'(0));
    tick();
    rst = 0;
    tick();
    run_op(64'hDEAD_BEEF_CAFE_F00D, 64'h2152_4110_3501_0FF3, 0);
    // start held high re-triggers every N+2 cycles
    op_a = 64'h8000_0000_0000_0001; op_b = 64'h8000_0000_0000_FFFF; cin = 0; start = 1;
    repeat (20) tick();
    start = 0;
    repeat (N + 2) tick();
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
      run_op(a, b, 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();
    chk("queue_drained", 80'(q.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
